// File: rtl/digit_frame_scheduler_pkg.sv
// Shared constants and FSM state type for the digit frame scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package digit_frame_scheduler_pkg;

  localparam int IMG_W     = 28;
  localparam int IMG_H     = 28;
  localparam int IMG_PIX   = IMG_W * IMG_H;
  localparam int XY_W      = 5;
  localparam int PIX_CNT_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOCK,
    START,
    STREAM,
    WAIT_RES
  } state_t;

  // True when (x,y) is the last raster position of the frame.
  function automatic logic is_last_xy(input logic [XY_W-1:0] x, input logic [XY_W-1:0] y);
    return (x == XY_W'(IMG_W - 1)) && (y == XY_W'(IMG_H - 1));
  endfunction

endpackage

// File: rtl/digit_frame_scheduler_if.sv
// Classifier-side link: start handshake, raster pixel stream and result return.
// Latency: n/a (wiring only).
// Backpressure: pixel stream uses valid/ready; start is gated by the classifier's idle flag.
interface digit_frame_scheduler_if;

  logic       nn_idle;
  logic       nn_start;
  logic       nn_pix_data;
  logic       nn_pix_valid;
  logic       nn_pix_ready;
  logic       nn_pix_last;
  logic       nn_done;
  logic [3:0] nn_class;

  modport master (
    input  nn_idle, nn_pix_ready, nn_done, nn_class,
    output nn_start, nn_pix_data, nn_pix_valid, nn_pix_last
  );

  modport slave (
    output nn_idle, nn_pix_ready, nn_done, nn_class,
    input  nn_start, nn_pix_data, nn_pix_valid, nn_pix_last
  );

endinterface

// File: rtl/digit_frame_scheduler_pix_skid_fifo2.sv
// Two-entry, one-bit skid FIFO feeding the classifier pixel stream.
// Latency: data pushed in cycle t is visible at the output in cycle t+1 (no fall-through).
// Backpressure: not_empty acts as valid, pop as ready; a push into a full FIFO is dropped unless a pop frees a slot.
module pix_skid_fifo2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       push_data,
  input  logic       pop,
  output logic       pop_data,
  output logic       not_empty,
  output logic [1:0] count
);

  logic [1:0] mem;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && ((count != 2'd2) || do_pop);
  assign pop_data  = mem[rd_ptr];
  assign not_empty = (count != 2'd0);

  // Storage, pointers and occupancy; a simultaneous push/pop keeps the count steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= 2'b00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/digit_frame_scheduler.sv
// Sequences one classification per 28x28 binary frame and shares the buffer read port with the HDMI scaler.
// Latency: frame_done -> nn_start 2 cycles when the classifier is idle; display read data returns 1 cycle after request.
// Backpressure: display always wins the read port; classifier reads issue only with FIFO credit; frames arriving while busy are dropped and counted.
module digit_frame_scheduler
  import digit_frame_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                     pixel_clk,
  input  logic                     rst_n,
  input  logic                     frame_done,
  input  logic                     disp_req,
  input  logic [XY_W-1:0]          disp_x,
  input  logic [XY_W-1:0]          disp_y,
  output logic                     disp_data,
  output logic [XY_W-1:0]          buf_rd_x,
  output logic [XY_W-1:0]          buf_rd_y,
  input  logic                     buf_rd_data,
  output logic                     buf_lock,
  digit_frame_scheduler_if.master  nn,
  output logic [3:0]               result_digit,
  output logic                     result_valid,
  output logic                     timeout_err,
  output logic [7:0]               drop_cnt
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t               state;
  logic [XY_W-1:0]      px;
  logic [XY_W-1:0]      py;
  logic                 ptr_done;
  logic [PIX_CNT_W-1:0] tx_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic                 disp_q;
  logic                 nn_rd_q;
  logic [1:0]           fifo_count;
  logic                 fifo_vld;
  logic                 fifo_dat;
  logic                 xfer;
  logic                 credit;
  logic                 issue;

  // A read may issue when the FIFO can still absorb it after counting the read already in
  // flight and any pixel leaving this cycle; counting the pop keeps the stream at one pixel per cycle.
  assign xfer   = fifo_vld & nn.nn_pix_ready;
  assign credit = (({1'b0, fifo_count} + {2'b00, nn_rd_q}) - {2'b00, xfer}) < 3'd2;
  assign issue  = (state == STREAM) && !disp_req && !ptr_done && credit;

  assign buf_rd_x  = disp_req ? disp_x : px;
  assign buf_rd_y  = disp_req ? disp_y : py;
  assign disp_data = disp_q & buf_rd_data;
  assign buf_lock  = (state != IDLE);

  assign nn.nn_pix_valid = fifo_vld;
  assign nn.nn_pix_data  = fifo_dat;
  assign nn.nn_pix_last  = fifo_vld && (tx_cnt == PIX_CNT_W'(IMG_PIX - 1));

  pix_skid_fifo2 u_fifo (
    .clk       (pixel_clk),
    .rst_n     (rst_n),
    .push      (nn_rd_q),
    .push_data (buf_rd_data),
    .pop       (xfer),
    .pop_data  (fifo_dat),
    .not_empty (fifo_vld),
    .count     (fifo_count)
  );

  // Remember who owned the read port last cycle so the returning data goes to the right consumer.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q  <= 1'b0;
      nn_rd_q <= 1'b0;
    end else begin
      disp_q  <= disp_req;
      nn_rd_q <= issue;
    end
  end

  // Raster read pointer: advances on each classifier read, parks after the last pixel, rewinds in IDLE.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      px       <= '0;
      py       <= '0;
      ptr_done <= 1'b0;
    end else if (state == IDLE) begin
      px       <= '0;
      py       <= '0;
      ptr_done <= 1'b0;
    end else if (issue) begin
      if (is_last_xy(px, py)) begin
        px       <= '0;
        ptr_done <= 1'b1;
      end else if (px == XY_W'(IMG_W - 1)) begin
        px <= '0;
        py <= py + XY_W'(1);
      end else begin
        px <= px + XY_W'(1);
      end
    end
  end

  // Frame FSM with registered start/result/error outputs and the saturating drop counter.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tx_cnt       <= '0;
      to_cnt       <= '0;
      nn.nn_start  <= 1'b0;
      result_digit <= 4'd0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      drop_cnt     <= 8'd0;
    end else begin
      nn.nn_start  <= 1'b0;
      result_valid <= 1'b0;
      if (frame_done && (state != IDLE) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          tx_cnt <= '0;
          if (frame_done) begin
            state <= LOCK;
          end
        end
        LOCK: begin
          nn.nn_start <= nn.nn_idle;
          state       <= START;
        end
        START: begin
          if (nn.nn_start) begin
            state <= STREAM;
          end else begin
            nn.nn_start <= nn.nn_idle;
          end
        end
        STREAM: begin
          if (xfer) begin
            tx_cnt <= tx_cnt + PIX_CNT_W'(1);
            if (tx_cnt == PIX_CNT_W'(IMG_PIX - 1)) begin
              state  <= WAIT_RES;
              to_cnt <= '0;
            end
          end
        end
        WAIT_RES: begin
          if (nn.nn_done) begin
            result_digit <= nn.nn_class;
            result_valid <= 1'b1;
            timeout_err  <= 1'b0;
            state        <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_frame_scheduler.sv
// Randomized bench for digit_frame_scheduler against a frame-level reference model.
// Latency: checks start latency, stream throughput, result capture and timeout timing.
// Backpressure: drives random classifier ready and interleaved display reads.
module tb_digit_frame_scheduler;
  import digit_frame_scheduler_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       frame_done;
  logic       disp_req;
  logic [4:0] disp_x;
  logic [4:0] disp_y;
  logic       disp_data;
  logic [4:0] buf_rd_x;
  logic [4:0] buf_rd_y;
  logic       buf_rd_data;
  logic       buf_lock;
  logic [3:0] result_digit;
  logic       result_valid;
  logic       timeout_err;
  logic [7:0] drop_cnt;

  digit_frame_scheduler_if nn_if ();

  digit_frame_scheduler #(.TIMEOUT_CYC(16)) dut (
    .pixel_clk    (clk),
    .rst_n        (rst_n),
    .frame_done   (frame_done),
    .disp_req     (disp_req),
    .disp_x       (disp_x),
    .disp_y       (disp_y),
    .disp_data    (disp_data),
    .buf_rd_x     (buf_rd_x),
    .buf_rd_y     (buf_rd_y),
    .buf_rd_data  (buf_rd_data),
    .buf_lock     (buf_lock),
    .nn           (nn_if.master),
    .result_digit (result_digit),
    .result_valid (result_valid),
    .timeout_err  (timeout_err),
    .drop_cnt     (drop_cnt)
  );

  bit img [IMG_PIX];
  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Binary image buffer model: one-cycle read latency.
  always @(posedge clk) buf_rd_data <= img[int'(buf_rd_y) * IMG_W + int'(buf_rd_x)];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse frame_done and count cycles until nn_start; classifier becomes idle d cycles in.
  task automatic start_frame(input int d, output int lat);
    nn_if.nn_idle = (d == 0);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    lat = 1;
    while (!nn_if.nn_start && lat < 50) begin
      if (lat >= d) nn_if.nn_idle = 1'b1;
      step();
      lat++;
    end
    nn_if.nn_idle = 1'b1;
  endtask

  // Consume one full frame and compare it with the image in raster order.
  task automatic run_stream(input string tag, input int rdy_pct, input bit disp_alt,
                            input int drops, output int cycles);
    int  k, derr, serr, lerr, maxc, fired, pidx;
    bit  preq;
    k = 0; derr = 0; serr = 0; lerr = 0; maxc = 0; fired = 0; pidx = 0;
    preq = 1'b0;
    cycles = 0;
    while (k < IMG_PIX && cycles < 20000) begin
      if (preq && (disp_data !== img[pidx])) derr++;
      if (int'(dut.fifo_count) > maxc) maxc = int'(dut.fifo_count);
      nn_if.nn_pix_ready = ($urandom_range(99) < rdy_pct);
      if (nn_if.nn_pix_valid && (nn_if.nn_pix_last !== (k == IMG_PIX - 1))) lerr++;
      if (nn_if.nn_pix_valid && nn_if.nn_pix_ready) begin
        if (nn_if.nn_pix_data !== img[k]) serr++;
        k++;
      end
      preq = disp_alt && (cycles % 2 == 0);
      if (preq) begin
        disp_x = 5'($urandom_range(IMG_W - 1));
        disp_y = 5'($urandom_range(IMG_H - 1));
        pidx   = int'(disp_y) * IMG_W + int'(disp_x);
      end
      disp_req = preq;
      frame_done = (fired < drops) && (cycles % 40 == 5);
      if (frame_done) fired++;
      step();
      cycles++;
    end
    nn_if.nn_pix_ready = 1'b0;
    disp_req   = 1'b0;
    frame_done = 1'b0;
    chk({tag, "_xfers"}, k, IMG_PIX);
    chk({tag, "_pix_err"}, serr, 0);
    chk({tag, "_last_err"}, lerr, 0);
    chk({tag, "_disp_err"}, derr, 0);
    chk({tag, "_fifo_ovf"}, (maxc <= 2), 1);
  endtask

  initial begin
    int       lat, cyc, bad, ns_cnt;
    logic [3:0] cls;
    rst_n = 1'b0; frame_done = 1'b0; disp_req = 1'b0; disp_x = '0; disp_y = '0;
    nn_if.nn_idle = 1'b1; nn_if.nn_pix_ready = 1'b0; nn_if.nn_done = 1'b0; nn_if.nn_class = '0;
    repeat (3) step();

    // Reset state
    chk("rst_start", nn_if.nn_start, 0);
    chk("rst_valid", nn_if.nn_pix_valid, 0);
    chk("rst_lock", buf_lock, 0);
    chk("rst_res_valid", result_valid, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_digit", result_digit, 0);
    rst_n = 1'b1;
    step();

    // Checkerboard, full ready, no display traffic
    for (int i = 0; i < IMG_PIX; i++) img[i] = bit'(((i % IMG_W) + (i / IMG_W)) % 2);
    start_frame(0, lat);
    chk("cb_latency", lat, 2);
    chk("cb_lock", buf_lock, 1);
    step();
    chk("cb_start_pulse", nn_if.nn_start, 0);
    run_stream("cb", 100, 1'b0, 0, cyc);
    chk("cb_stream_time", (cyc >= IMG_PIX) && (cyc <= IMG_PIX + 6), 1);
    chk("cb_wait_lock", buf_lock, 1);
    nn_if.nn_class = 4'd7; nn_if.nn_done = 1'b1;
    step();
    nn_if.nn_done = 1'b0; nn_if.nn_class = 4'd0;
    chk("cb_res_valid", result_valid, 1);
    chk("cb_res_digit", result_digit, 7);
    chk("cb_lock_fall", buf_lock, 0);
    step();
    chk("cb_res_pulse", result_valid, 0);
    chk("cb_drop", drop_cnt, 0);

    // Random frame, late classifier idle, display on alternate cycles, 50% ready, 3 drops
    for (int i = 0; i < IMG_PIX; i++) img[i] = bit'($urandom_range(1));
    start_frame(5, lat);
    chk("rnd_latency", lat, 6);
    run_stream("rnd", 50, 1'b1, 3, cyc);
    chk("rnd_drop", drop_cnt, 3);

    // No result: abort after 16 cycles in WAIT_RES
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (timeout_err || !buf_lock) bad++;
      step();
    end
    chk("to_early", bad, 0);
    chk("to_err", timeout_err, 1);
    chk("to_idle", buf_lock, 0);
    chk("to_no_result", result_valid, 0);

    // Drop counter saturation while the stream is stalled
    for (int i = 0; i < IMG_PIX; i++) img[i] = bit'($urandom_range(1));
    start_frame(0, lat);
    for (int i = 0; i < 600; i++) begin
      frame_done = (i % 2 == 0);
      step();
    end
    frame_done = 1'b0;
    chk("sat_drop", drop_cnt, 255);
    run_stream("sat", 80, 1'b1, 2, cyc);
    chk("sat_hold", drop_cnt, 255);
    chk("sat_err_kept", timeout_err, 1);
    cls = 4'($urandom_range(9));
    nn_if.nn_class = cls; nn_if.nn_done = 1'b1;
    step();
    nn_if.nn_done = 1'b0;
    chk("clr_err", timeout_err, 0);
    chk("clr_digit", result_digit, cls);

    // Second timeout, then nn_done on the final timeout cycle wins
    start_frame(0, lat);
    run_stream("to2", 100, 1'b0, 0, cyc);
    repeat (16) step();
    chk("to2_err", timeout_err, 1);
    start_frame(0, lat);
    run_stream("edge", 90, 1'b0, 0, cyc);
    repeat (15) step();
    chk("edge_lock", buf_lock, 1);
    cls = 4'($urandom_range(9));
    nn_if.nn_class = cls; nn_if.nn_done = 1'b1;
    step();
    nn_if.nn_done = 1'b0;
    chk("edge_valid", result_valid, 1);
    chk("edge_digit", result_digit, cls);
    chk("edge_err", timeout_err, 0);

    // Reset in the middle of a stream
    start_frame(0, lat);
    nn_if.nn_pix_ready = 1'b1;
    repeat (100) step();
    nn_if.nn_pix_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ns_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      ns_cnt += int'(nn_if.nn_start);
      step();
    end
    chk("mrst_no_start", ns_cnt, 0);
    chk("mrst_lock", buf_lock, 0);
    chk("mrst_drop", drop_cnt, 0);
    chk("mrst_err", timeout_err, 0);
    for (int i = 0; i < IMG_PIX; i++) img[i] = bit'($urandom_range(1));
    start_frame(0, lat);
    chk("mrst_latency", lat, 2);
    run_stream("mrst", 70, 1'b1, 0, cyc);
    nn_if.nn_class = 4'd2; nn_if.nn_done = 1'b1;
    step();
    nn_if.nn_done = 1'b0;
    chk("mrst_digit", result_digit, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
